// File: rtl/multicycle_main_fsm.sv
// Main control FSM for the multicycle RISC-V datapath: sequences fetch/decode/
// execute/memory/writeback, stalls on the cache ready handshake, traps faults.
module multicycle_main_fsm #(
  parameter int MEM_TIMEOUT  = 16,
  parameter bit TRAP_ILLEGAL = 1'b1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [6:0] OP6_0,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc1_0,
  output logic [1:0] ALUSrcA1_0,
  output logic [1:0] ALUSrcB1_0,
  output logic [1:0] ImmSrc1_0,
  output logic [1:0] ALUOP1_0,
  output logic       RegWrite,
  output logic       InstrDone,
  output logic       Fault
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWRITE, S_MEMWB,
    S_EXECR, S_EXECI, S_ALUWB, S_BEQ, S_JAL, S_FAULT
  } state_t;

  typedef struct packed {
    logic       adr;
    logic       mrd;
    logic       mwr;
    logic [1:0] rs;
    logic [1:0] sa;
    logic [1:0] sb;
    logic [1:0] aop;
    logic       rw;
    logic       flt;
  } moore_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = (MEM_TIMEOUT > 0) ? CW'(MEM_TIMEOUT - 1) : '0;
  localparam logic [CW-1:0] CNT_MAX  = '1;

  // Pure state-decoded outputs; registered from the next state so they
  // change together with the state register.
  function automatic moore_t moore_of(state_t s);
    moore_t m;
    m = '0;
    case (s)
      S_FETCH:    begin m.mrd = 1'b1; m.sb = 2'b10; m.rs = 2'b10; end
      S_DECODE:   begin m.sa = 2'b01; m.sb = 2'b01; end
      S_MEMADR:   begin m.sa = 2'b10; m.sb = 2'b01; end
      S_MEMREAD:  begin m.adr = 1'b1; m.mrd = 1'b1; end
      S_MEMWRITE: begin m.adr = 1'b1; m.mwr = 1'b1; end
      S_MEMWB:    begin m.rs = 2'b01; m.rw = 1'b1; end
      S_EXECR:    begin m.sa = 2'b10; m.aop = 2'b10; end
      S_EXECI:    begin m.sa = 2'b10; m.sb = 2'b01; m.aop = 2'b10; end
      S_ALUWB:    begin m.rw = 1'b1; end
      S_BEQ:      begin m.sa = 2'b10; m.aop = 2'b01; end
      S_JAL:      begin m.sa = 2'b01; m.sb = 2'b10; end
      S_FAULT:    begin m.flt = 1'b1; end
      default:    m = '0;
    endcase
    return m;
  endfunction

  state_t        state;
  state_t        nxt;
  moore_t        mo;
  logic [CW-1:0] cnt;
  logic          waiting;
  logic          timeout;
  logic          legal;

  always_comb begin
    waiting = (state == S_FETCH) || (state == S_MEMREAD) || (state == S_MEMWRITE);
    timeout = (MEM_TIMEOUT > 0) && waiting && !MemReady && (cnt == CNT_LAST);
    legal   = (OP6_0 == OP_LW) || (OP6_0 == OP_SW) || (OP6_0 == OP_R) ||
              (OP6_0 == OP_I) || (OP6_0 == OP_BEQ) || (OP6_0 == OP_JAL);
    nxt = state;
    case (state)
      S_FETCH:    if (MemReady) nxt = S_DECODE;
      S_DECODE: begin
        case (OP6_0)
          OP_LW, OP_SW: nxt = S_MEMADR;
          OP_R:         nxt = S_EXECR;
          OP_I:         nxt = S_EXECI;
          OP_BEQ:       nxt = S_BEQ;
          OP_JAL:       nxt = S_JAL;
          default:      nxt = TRAP_ILLEGAL ? S_FAULT : S_FETCH;
        endcase
      end
      S_MEMADR:   nxt = (OP6_0 == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (MemReady) nxt = S_MEMWB;
      S_MEMWRITE: if (MemReady) nxt = S_FETCH;
      S_EXECR, S_EXECI, S_JAL: nxt = S_ALUWB;
      S_MEMWB, S_ALUWB, S_BEQ: nxt = S_FETCH;
      S_FAULT:    nxt = S_FAULT;
      default:    nxt = S_FAULT;
    endcase
    // A ready in the same cycle always beats the timeout.
    if (timeout) nxt = S_FAULT;
  end

  // Stage p0: state, wait counter and registered Moore outputs.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state <= S_FETCH;
      cnt   <= '0;
      mo    <= moore_of(S_FETCH);
    end else begin
      state <= nxt;
      mo    <= moore_of(nxt);
      if (waiting && !MemReady)
        cnt <= (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
      else
        cnt <= '0;
    end
  end

  always_comb begin
    IRWrite   = (state == S_FETCH) && MemReady;
    PCWrite   = IRWrite || (state == S_JAL) || ((state == S_BEQ) && Zero);
    InstrDone = (state == S_MEMWB) || (state == S_ALUWB) || (state == S_BEQ) ||
                ((state == S_MEMWRITE) && MemReady) ||
                ((state == S_DECODE) && !legal && !TRAP_ILLEGAL);
    ImmSrc1_0 = 2'b00;
    if ((state != S_FETCH) && (state != S_FAULT)) begin
      case (OP6_0)
        OP_SW:   ImmSrc1_0 = 2'b01;
        OP_BEQ:  ImmSrc1_0 = 2'b10;
        OP_JAL:  ImmSrc1_0 = 2'b11;
        default: ImmSrc1_0 = 2'b00;
      endcase
    end
  end

  assign AdrSrc       = mo.adr;
  assign MemRead      = mo.mrd;
  assign MemWrite     = mo.mwr;
  assign ResultSrc1_0 = mo.rs;
  assign ALUSrcA1_0   = mo.sa;
  assign ALUSrcB1_0   = mo.sb;
  assign ALUOP1_0     = mo.aop;
  assign RegWrite     = mo.rw;
  assign Fault        = mo.flt;

endmodule

// File: tb/tb_multicycle_main_fsm.sv
// Bench for multicycle_main_fsm: three parameterisations driven in turn from
// an instruction-level model that expands each instruction into its phases.
module tb_multicycle_main_fsm;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [6:0] OP6_0 = 7'd0;
  logic       Zero = 1'b0;
  logic       MemReady = 1'b0;

  always #5 CLK = ~CLK;

  logic       pcw[3], adr[3], mrd[3], mwr[3], irw[3], rw[3], dn[3], flt[3];
  logic [1:0] rs[3], sa[3], sb[3], imm[3], aop[3];
  logic [17:0] ob[3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    multicycle_main_fsm #(
      .MEM_TIMEOUT (g == 0 ? 16 : (g == 1 ? 4 : 0)),
      .TRAP_ILLEGAL(g != 2)
    ) dut (
      .CLK(CLK), .RST(RST), .OP6_0(OP6_0), .Zero(Zero), .MemReady(MemReady),
      .PCWrite(pcw[g]), .AdrSrc(adr[g]), .MemRead(mrd[g]), .MemWrite(mwr[g]),
      .IRWrite(irw[g]), .ResultSrc1_0(rs[g]), .ALUSrcA1_0(sa[g]),
      .ALUSrcB1_0(sb[g]), .ImmSrc1_0(imm[g]), .ALUOP1_0(aop[g]),
      .RegWrite(rw[g]), .InstrDone(dn[g]), .Fault(flt[g])
    );
    assign ob[g] = {pcw[g], adr[g], mrd[g], mwr[g], irw[g], rs[g], sa[g], sb[g],
                    imm[g], aop[g], rw[g], dn[g], flt[g]};
  end

  localparam logic [6:0] OP_LW = 7'b0000011, OP_SW = 7'b0100011, OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011, OP_BEQ = 7'b1100011, OP_JAL = 7'b1101111;

  localparam int P_F = 0, P_D = 1, P_MA = 2, P_MR = 3, P_MW = 4, P_MWB = 5;
  localparam int P_EXR = 6, P_EXI = 7, P_AWB = 8, P_BEQ = 9, P_JAL = 10, P_FLT = 11;
  string pname[12] = '{"fetch", "decode", "memadr", "memread", "memwrite", "memwb",
                       "execr", "execi", "aluwb", "beq", "jal", "fault"};

  typedef struct { int p; logic rdy; } ent_t;
  ent_t q[$];

  int errs = 0;
  int checks = 0;
  int sel = 0;

  task automatic chk(input string tag, input logic [17:0] got, input logic [17:0] want);
    checks++;
    if (got !== want) begin
      errs++;
      $display("FAIL %s: got %b want %b (pcw adr mrd mwr irw rs sa sb imm aop rw done flt)",
               tag, got, want);
    end
  endtask

  function automatic bit is_legal(logic [6:0] op);
    return op == OP_LW || op == OP_SW || op == OP_R || op == OP_I || op == OP_BEQ || op == OP_JAL;
  endfunction

  function automatic logic [1:0] imm_of(logic [6:0] op);
    if (op == OP_SW)  return 2'b01;
    if (op == OP_BEQ) return 2'b10;
    if (op == OP_JAL) return 2'b11;
    return 2'b00;
  endfunction

  // Expected outputs for one cycle spent in phase p, straight from the state table.
  function automatic logic [17:0] exp_out(int p, logic rdy, logic z, logic [6:0] op, bit trap);
    logic e_pcw = 0, e_adr = 0, e_mrd = 0, e_mwr = 0, e_irw = 0, e_rw = 0, e_dn = 0, e_flt = 0;
    logic [1:0] e_rs = 0, e_sa = 0, e_sb = 0, e_imm = 0, e_aop = 0;
    case (p)
      P_F:   begin e_mrd = 1; e_sb = 2; e_rs = 2; e_irw = rdy; e_pcw = rdy; end
      P_D:   begin e_sa = 1; e_sb = 1; e_dn = !is_legal(op) && !trap; end
      P_MA:  begin e_sa = 2; e_sb = 1; end
      P_MR:  begin e_adr = 1; e_mrd = 1; end
      P_MW:  begin e_adr = 1; e_mwr = 1; e_dn = rdy; end
      P_MWB: begin e_rs = 1; e_rw = 1; e_dn = 1; end
      P_EXR: begin e_sa = 2; e_sb = 0; e_aop = 2; end
      P_EXI: begin e_sa = 2; e_sb = 1; e_aop = 2; end
      P_AWB: begin e_rs = 0; e_rw = 1; e_dn = 1; end
      P_BEQ: begin e_sa = 2; e_aop = 1; e_pcw = z; e_dn = 1; end
      P_JAL: begin e_sa = 1; e_sb = 2; e_pcw = 1; end
      default: e_flt = 1;
    endcase
    if (p != P_F && p != P_FLT) e_imm = imm_of(op);
    return {e_pcw, e_adr, e_mrd, e_mwr, e_irw, e_rs, e_sa, e_sb, e_imm, e_aop, e_rw, e_dn, e_flt};
  endfunction

  task automatic push(input int p, input logic r);
    ent_t e;
    e.p = p;
    e.rdy = r;
    q.push_back(e);
  endtask

  // A memory phase: w not-ready cycles then ready, unless the timeout t fires first.
  task automatic push_mem(input int p, input int w, input int t, output bit dead);
    dead = 0;
    if (t > 0 && w >= t) begin
      for (int i = 0; i < t; i++) push(p, 1'b0);
      for (int i = 0; i < 3; i++) push(P_FLT, 1'($urandom));
      dead = 1;
    end else begin
      for (int i = 0; i < w; i++) push(p, 1'b0);
      push(p, 1'b1);
    end
  endtask

  task automatic do_reset();
    RST = 1'b0;
    MemReady = 1'b0;
    @(posedge CLK); #1;
    #3 chk($sformatf("rst_idle dut%0d", sel), ob[sel], exp_out(P_F, 1'b0, Zero, OP6_0, 1'b1));
    MemReady = 1'b1;
    #1 chk($sformatf("rst_rdy dut%0d", sel), ob[sel], exp_out(P_F, 1'b1, Zero, OP6_0, 1'b1));
    @(posedge CLK); #1;
    RST = 1'b1;
    MemReady = 1'b0;
  endtask

  // Expands one instruction into phases and checks every cycle. faulted=1
  // means the DUT is now in FAULT and the caller must reset it.
  task automatic run_instr(input logic [6:0] op, input int wf, input int wm,
                           input int zmode, input int abort_at, output bit faulted);
    int t = (sel == 0) ? 16 : ((sel == 1) ? 4 : 0);
    bit trap = (sel != 2);
    bit dead;
    q.delete();
    push_mem(P_F, wf, t, dead);
    if (!dead) begin
      push(P_D, 1'($urandom));
      case (op)
        OP_LW: begin
          push(P_MA, 1'($urandom));
          push_mem(P_MR, wm, t, dead);
          if (!dead) push(P_MWB, 1'($urandom));
        end
        OP_SW: begin
          push(P_MA, 1'($urandom));
          push_mem(P_MW, wm, t, dead);
        end
        OP_R:   begin push(P_EXR, 1'($urandom)); push(P_AWB, 1'($urandom)); end
        OP_I:   begin push(P_EXI, 1'($urandom)); push(P_AWB, 1'($urandom)); end
        OP_BEQ: push(P_BEQ, 1'($urandom));
        OP_JAL: begin push(P_JAL, 1'($urandom)); push(P_AWB, 1'($urandom)); end
        default: if (trap) begin
          for (int i = 0; i < 3; i++) push(P_FLT, 1'($urandom));
          dead = 1;
        end
      endcase
    end
    faulted = dead;
    OP6_0 = op;
    foreach (q[i]) begin
      MemReady = q[i].rdy;
      Zero = (zmode == 2) ? 1'($urandom) : (zmode == 1);
      #3 chk($sformatf("%s op=%b c%0d dut%0d", pname[q[i].p], op, i, sel), ob[sel],
             exp_out(q[i].p, MemReady, Zero, op, trap));
      if (i == abort_at) begin
        do_reset();
        faulted = 0;
        return;
      end
      @(posedge CLK); #1;
    end
  endtask

  logic [6:0] ops[6] = '{OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL};

  initial begin
    bit f;
    logic [6:0] op;
    int r, wf, wm;

    sel = 0;
    do_reset();
    run_instr(OP_LW, 0, 0, 2, -1, f);
    run_instr(OP_SW, 0, 2, 2, -1, f);
    run_instr(OP_BEQ, 0, 0, 1, -1, f);
    run_instr(OP_BEQ, 0, 0, 0, -1, f);
    run_instr(OP_JAL, 1, 0, 2, -1, f);
    run_instr(OP_R, 0, 0, 2, -1, f);
    run_instr(OP_I, 2, 0, 2, -1, f);
    run_instr(7'b1111111, 0, 0, 2, -1, f);
    if (f) do_reset();
    run_instr(OP_LW, 0, 5, 2, 4, f);
    run_instr(OP_LW, 0, 0, 2, -1, f);

    sel = 1;
    do_reset();
    run_instr(OP_LW, 4, 0, 2, -1, f);
    if (f) do_reset();
    run_instr(OP_LW, 3, 3, 2, -1, f);
    run_instr(OP_SW, 0, 4, 2, -1, f);
    if (f) do_reset();
    run_instr(OP_LW, 0, 3, 2, 4, f);
    run_instr(OP_LW, 3, 3, 2, -1, f);

    sel = 2;
    do_reset();
    run_instr(7'b1111111, 0, 0, 2, -1, f);
    run_instr(OP_LW, 20, 20, 2, -1, f);

    for (int s = 0; s < 3; s++) begin
      sel = s;
      do_reset();
      for (int n = 0; n < 40; n++) begin
        r = $urandom_range(0, 6);
        if (r < 6) op = ops[r];
        else begin
          op = 7'($urandom);
          while (is_legal(op)) op = 7'($urandom);
        end
        r = $urandom_range(0, 9);
        wf = (r < 6) ? 0 : ((r < 9) ? $urandom_range(1, 3) : $urandom_range(3, 18));
        r = $urandom_range(0, 9);
        wm = (r < 6) ? 0 : ((r < 9) ? $urandom_range(1, 3) : $urandom_range(3, 18));
        run_instr(op, wf, wm, 2, -1, f);
        if (f) do_reset();
      end
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, errors=%0d of %0d checks", errs, checks);
    $fatal(1, "bench timeout");
  end

endmodule
